comparator_2bit_reg: RTL and testbench
======================================

Name: comparator_2bit_reg

Overview:
Registered magnitude comparator for two operands, A and B.
- Produces equal, not-equal, A-greater and B-greater flags.
- Flags are registered on the single system clock and qualified by a valid strobe.
- Used as a leaf compare stage wherever downstream logic needs clean, glitch-free relation flags one cycle after the operands are presented.

Parameters:
- WIDTH, 1, operand width in bits; must be at least 1. The default of 1 gives the two single-bit operands used in the standard configuration.
- SIGNED, 0, operand interpretation: 0 treats operands as unsigned; 1 treats them as two's-complement signed.

Ports:
- i_clk  input  1  system clock; all state updates on the rising edge.
- i_rst  input  1  synchronous reset, active-high.
- i_valid  input  1  operands on i_a/i_b are valid this cycle.
- i_a  input  WIDTH  operand A.
- i_b  input  WIDTH  operand B.
- o_valid  output  1  flags were updated from a valid compare on the previous edge.
- o_equal  output  1  A == B.
- o_not_equal  output  1  A != B.
- o_great_a  output  1  A > B.
- o_great_b  output  1  B > A.

Behaviour:
- Interface: one clock, i_clk. Reset i_rst is synchronous and active-high. All outputs are registers.
- Reset: on a rising edge with i_rst=1, every output is cleared to 0: o_valid, o_equal, o_not_equal, o_great_a, o_great_b. Reset has priority over i_valid in the same cycle.
- Latency: exactly 1 clock. Operands sampled at edge N appear on the flags right after edge N.
- Valid compare: on an edge with i_valid=1 and i_rst=0:
  - o_equal <= (A==B)
  - o_not_equal <= (A!=B)
  - o_great_a <= (A>B)
  - o_great_b <= (B>A)
  - o_valid <= 1
- Idle: on an edge with i_valid=0 and i_rst=0, o_valid <= 0 and all four flags hold their previous values.
- Invariants after any valid compare:
  - exactly one of o_equal, o_great_a, o_great_b is 1;
  - o_not_equal == ~o_equal;
  - o_great_a and o_great_b are never both 1.
- Output after reset: all flags are 0 (the only legal all-zero state) until the first valid compare.
- Signed mode (SIGNED=1): MSB is the sign bit. With WIDTH=2, -2 (10) < -1 (11) < 0 (00) < 1 (01). With WIDTH=1, 1 represents -1, so 1 < 0.
- Unsigned mode: plain binary magnitude. With WIDTH=1, 1 > 0.
- Back-to-back: i_valid held high for consecutive cycles gives a new result every cycle, with no bubbles.
- Reset mid-stream: a compare whose sampling edge coincides with i_rst=1 is discarded. The next valid compare after reset deasserts proceeds normally.
- No X propagation: with i_valid=0, operand values do not affect any output.

Decomposition:
- Package comparator_pkg holds a localparam for the default WIDTH and a 4-bit relation encoding (EQ, NE, GA, GB bit positions) shared with consumers.
- One combinational sub-module, comparator_cell. It takes A, B and SIGNED and produces the four unregistered relation bits.
- The top module adds the valid/reset register stage around comparator_cell.

Test Plan:
1. Exhaustive unsigned, WIDTH=1. Drive a 2-bit counter 0..3 every 10 ns with i_a=cnt[0], i_b=cnt[1], i_valid=1. Required flags one cycle later:
   - (0,0) -> eq=1, ne=0, ga=0, gb=0
   - (1,0) -> eq=0, ne=1, ga=1, gb=0
   - (0,1) -> eq=0, ne=1, ga=0, gb=1
   - (1,1) -> eq=1, ne=0, ga=0, gb=0
   The counter wraps after 3, and the pattern repeats identically on the second pass.
2. Reset. Assert i_rst=1 with i_valid=1, a=1, b=0 -> all outputs 0 on the following edge. Deassert reset -> the next edge gives ga=1, o_valid=1.
3. Hold. After a compare of a=1, b=0, drop i_valid for 3 cycles while toggling operands -> o_valid=0 and flags stay at ga=1, ne=1 throughout.
4. Signed, WIDTH=2, SIGNED=1:
   - a=2'b11 (-1), b=2'b01 (+1) -> gb=1
   - a=2'b10, b=2'b10 -> eq=1
   - a=2'b00, b=2'b10 -> ga=1
5. Random back-to-back, WIDTH=8 unsigned. 1000 random pairs with i_valid=1 every cycle. A scoreboard checks each result one cycle later and asserts the one-hot invariant on {eq, ga, gb} on every cycle where o_valid=1.

Source files
------------

// File: rtl/comparator_pkg.sv
// Shared definitions for the registered magnitude comparator.
// Relation bit positions are shared with downstream consumers.
package comparator_pkg;

  localparam int unsigned CMP_WIDTH_DEF = 1;

  localparam int unsigned REL_EQ = 0;
  localparam int unsigned REL_NE = 1;
  localparam int unsigned REL_GA = 2;
  localparam int unsigned REL_GB = 3;

  typedef logic [3:0] rel_t;

  function automatic rel_t pack_rel(
    input logic eq,
    input logic ga,
    input logic gb
  );
    rel_t r;
    r         = '0;
    r[REL_EQ] = eq;
    r[REL_NE] = ~eq;
    r[REL_GA] = ga;
    r[REL_GB] = gb;
    return r;
  endfunction

endpackage

// File: rtl/comparator_cell.sv
// Combinational relation cell: equal, not-equal, A>B and B>A.
// SIGNED selects two's-complement or plain binary ordering.
module comparator_cell
  import comparator_pkg::*;
#(
  parameter int unsigned WIDTH  = CMP_WIDTH_DEF,
  parameter bit          SIGNED = 1'b0
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output rel_t             rel_o
);

  logic eq;
  logic ga;
  logic gb;

  assign eq = (a_i == b_i);

  generate
    if (SIGNED) begin : g_signed
      assign ga = ($signed(a_i) > $signed(b_i));
      assign gb = ($signed(b_i) > $signed(a_i));
    end else begin : g_unsigned
      assign ga = (a_i > b_i);
      assign gb = (b_i > a_i);
    end
  endgenerate

  assign rel_o = pack_rel(eq, ga, gb);

endmodule

// File: rtl/comparator_2bit_reg.sv
// Registered comparator: relation flags one cycle after a valid strobe.
// Flags hold while idle; o_valid marks a fresh result.
module comparator_2bit_reg
  import comparator_pkg::*;
#(
  parameter int unsigned WIDTH  = CMP_WIDTH_DEF,
  parameter bit          SIGNED = 1'b0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_valid,
  output logic             o_equal,
  output logic             o_not_equal,
  output logic             o_great_a,
  output logic             o_great_b
);

  rel_t rel;
  rel_t rel_d;
  rel_t rel_q;
  logic valid_d;
  logic valid_q;

  comparator_cell #(
    .WIDTH (WIDTH),
    .SIGNED(SIGNED)
  ) u_cell (
    .a_i  (i_a),
    .b_i  (i_b),
    .rel_o(rel)
  );

  // Operands are ignored entirely when not valid.
  always_comb begin
    rel_d   = rel_q;
    valid_d = 1'b0;
    if (i_valid) begin
      rel_d   = rel;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rel_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      rel_q   <= rel_d;
      valid_q <= valid_d;
    end
  end

  assign o_valid     = valid_q;
  assign o_equal     = rel_q[REL_EQ];
  assign o_not_equal = rel_q[REL_NE];
  assign o_great_a   = rel_q[REL_GA];
  assign o_great_b   = rel_q[REL_GB];

endmodule

// File: tb/tb_comparator_2bit_reg.sv
// Directed bench for comparator_2bit_reg: 1-bit unsigned,
// 2-bit signed and 8-bit unsigned instances.
module tb_comparator_2bit_reg;

  logic       clk;
  logic       rst;
  logic       valid;
  logic       a1, b1;
  logic [1:0] a2, b2;
  logic [7:0] a8, b8;

  logic v1, e1, n1, ga1, gb1;
  logic v2, e2, n2, ga2, gb2;
  logic v8, e8, n8, ga8, gb8;

  int n_chk;
  int n_err;

  comparator_2bit_reg u_w1 (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_valid    (valid),
    .i_a        (a1),
    .i_b        (b1),
    .o_valid    (v1),
    .o_equal    (e1),
    .o_not_equal(n1),
    .o_great_a  (ga1),
    .o_great_b  (gb1)
  );

  comparator_2bit_reg #(
    .WIDTH (2),
    .SIGNED(1'b1)
  ) u_s2 (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_valid    (valid),
    .i_a        (a2),
    .i_b        (b2),
    .o_valid    (v2),
    .o_equal    (e2),
    .o_not_equal(n2),
    .o_great_a  (ga2),
    .o_great_b  (gb2)
  );

  comparator_2bit_reg #(
    .WIDTH (8),
    .SIGNED(1'b0)
  ) u_w8 (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_valid    (valid),
    .i_a        (a8),
    .i_b        (b8),
    .o_valid    (v8),
    .o_equal    (e8),
    .o_not_equal(n8),
    .o_great_a  (ga8),
    .o_great_b  (gb8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed as {valid, eq, ne, ga, gb}.
  function automatic logic [4:0] f1();
    return {v1, e1, n1, ga1, gb1};
  endfunction

  function automatic logic [4:0] f2();
    return {v2, e2, n2, ga2, gb2};
  endfunction

  function automatic logic [4:0] f8();
    return {v8, e8, n8, ga8, gb8};
  endfunction

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [4:0] exp1 [4];
  logic [4:0] e8x;
  logic [7:0] ra, rb;

  initial begin
    n_chk = 0;
    n_err = 0;
    exp1[0] = 5'b1_1000;
    exp1[1] = 5'b1_0110;
    exp1[2] = 5'b1_0101;
    exp1[3] = 5'b1_1000;

    rst   = 1'b1;
    valid = 1'b0;
    a1 = 1'b0; b1 = 1'b0;
    a2 = 2'b00; b2 = 2'b00;
    a8 = 8'h00; b8 = 8'h00;
    step();
    step();
    chk("rst_w1", 32'(f1()), 32'h0);
    chk("rst_s2", 32'(f2()), 32'h0);
    chk("rst_w8", 32'(f8()), 32'h0);

    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      a1    = c[0];
      b1    = c[1];
      valid = 1'b1;
      step();
      chk($sformatf("exh%0d", c), 32'(f1()), 32'(exp1[c % 4]));
    end

    rst = 1'b1;
    a1  = 1'b1;
    b1  = 1'b0;
    step();
    chk("rst_pri", 32'(f1()), 32'h0);
    rst = 1'b0;
    step();
    chk("rst_rel", 32'(f1()), 32'b1_0110);

    valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a1 = i[0];
      b1 = ~i[0];
      a8 = 8'(i * 37);
      step();
      chk($sformatf("hold%0d", i), 32'(f1()), 32'b0_0110);
    end

    valid = 1'b1;
    a2 = 2'b11; b2 = 2'b01;
    step();
    chk("s_m1_p1", 32'(f2()), 32'b1_0101);
    a2 = 2'b10; b2 = 2'b10;
    step();
    chk("s_eq", 32'(f2()), 32'b1_1000);
    a2 = 2'b00; b2 = 2'b10;
    step();
    chk("s_0_m2", 32'(f2()), 32'b1_0110);
    a2 = 2'b01; b2 = 2'b11;
    step();
    chk("s_p1_m1", 32'(f2()), 32'b1_0110);

    a8 = 8'h00; b8 = 8'hFF;
    step();
    chk("w8_min", 32'(f8()), 32'b1_0101);
    a8 = 8'hFF; b8 = 8'h00;
    step();
    chk("w8_max", 32'(f8()), 32'b1_0110);

    for (int k = 0; k < 1000; k++) begin
      ra = 8'($urandom_range(0, 255));
      rb = (k % 8 == 0) ? ra : 8'($urandom_range(0, 255));
      a8 = ra;
      b8 = rb;
      e8x = {1'b1, ra == rb, ra != rb, ra > rb, rb > ra};
      step();
      chk("w8_rnd", 32'(f8()), 32'(e8x));
      if (v8)
        chk("onehot", 32'($countones({e8, ga8, gb8})), 32'd1);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_chk, n_err);
    $finish;
  end

endmodule
